datapath_2: RTL and testbench

4-bit register-file datapath driven by a 16-bit horizontal control word. Each cycle it reads two operands from a 7-entry register file or the external input, runs them through a 16-function ALU, and optionally writes the result back. It registers N/Z/C/V flags and drives a selectable 4-bit output. It sits under an external sequencer or controller that supplies one control word per clock.

---
 rtl/datapath_2.sv | 154 +++++++++++++++
 tb/tb_datapath_2.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_2.sv
// 4-bit register-file datapath: two read ports (address 0 = datain), 16-function ALU,
// write-back to r1..r7, registered N/Z/C/V flags and a selectable output.
module datapath_2 #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  control,
  input  logic [W-1:0] datain,
  output logic [3:0]   banderas,
  output logic [W-1:0] dataout
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned FW = 4;

  typedef enum logic [3:0] {
    OP_PASSA = 4'h0,
    OP_PASSB = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOTA  = 4'h7,
    OP_INC   = 4'h8,
    OP_DEC   = 4'h9,
    OP_SHL   = 4'hA,
    OP_SHR   = 4'hB,
    OP_ASR   = 4'hC,
    OP_ROL   = 4'hD,
    OP_ROR   = 4'hE,
    OP_ZERO  = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [AW-1:0] a_sel;
    logic [AW-1:0] b_sel;
    logic [AW-1:0] dest;
    alu_op_e       op;
    logic [AW-1:0] out_sel;
  } ctrl_t;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(control);

  logic [W-1:0]  regs_q [1:NREG-1];
  logic [W-1:0]  regs_d [1:NREG-1];
  logic [FW-1:0] flags_q, flags_d;

  logic [W-1:0] a_op, b_op;
  logic [W-1:0] alu_r;
  logic         alu_c, alu_v;
  logic [W:0]   sum;

  // Read ports: address 0 is the external operand, not storage.
  always_comb begin
    a_op = datain;
    b_op = datain;
    if (ctrl.a_sel != '0) a_op = regs_q[ctrl.a_sel];
    if (ctrl.b_sel != '0) b_op = regs_q[ctrl.b_sel];
  end

  // ALU; carry on subtract-style ops is the inverted borrow.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    sum   = '0;
    unique case (ctrl.op)
      OP_PASSA: alu_r = a_op;
      OP_PASSB: alu_r = b_op;
      OP_ADD: begin
        sum   = {1'b0, a_op} + {1'b0, b_op};
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (a_op[W-1] == b_op[W-1]) && (sum[W-1] != a_op[W-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a_op} + {1'b0, ~b_op} + (W+1)'(1);
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (a_op[W-1] != b_op[W-1]) && (sum[W-1] != a_op[W-1]);
      end
      OP_AND:  alu_r = a_op & b_op;
      OP_OR:   alu_r = a_op | b_op;
      OP_XOR:  alu_r = a_op ^ b_op;
      OP_NOTA: alu_r = ~a_op;
      OP_INC: begin
        sum   = {1'b0, a_op} + (W+1)'(1);
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = ~a_op[W-1] & sum[W-1];
      end
      OP_DEC: begin
        sum   = {1'b0, a_op} + {1'b0, {W{1'b1}}};
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = a_op[W-1] & ~sum[W-1];
      end
      OP_SHL: begin
        alu_r = {a_op[W-2:0], 1'b0};
        alu_c = a_op[W-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, a_op[W-1:1]};
        alu_c = a_op[0];
      end
      OP_ASR: begin
        alu_r = {a_op[W-1], a_op[W-1:1]};
        alu_c = a_op[0];
      end
      OP_ROL: begin
        alu_r = {a_op[W-2:0], a_op[W-1]};
        alu_c = a_op[W-1];
      end
      OP_ROR: begin
        alu_r = {a_op[0], a_op[W-1:1]};
        alu_c = a_op[0];
      end
      OP_ZERO: alu_r = '0;
      default: alu_r = '0;
    endcase
  end

  // Write-back and flag next state; flags update every cycle regardless of dest.
  always_comb begin
    for (int unsigned k = 1; k < NREG; k++) begin
      regs_d[k] = regs_q[k];
      if (ctrl.dest == AW'(k)) regs_d[k] = alu_r;
    end
    flags_d = {alu_r[W-1], (alu_r == '0), alu_c, alu_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 1; k < NREG; k++) regs_q[k] <= '0;
      flags_q <= '0;
    end else begin
      for (int unsigned k = 1; k < NREG; k++) regs_q[k] <= regs_d[k];
      flags_q <= flags_d;
    end
  end

  // Output mux: select 0 shows the live ALU result.
  always_comb begin
    dataout = alu_r;
    if (ctrl.out_sel != '0) dataout = regs_q[ctrl.out_sel];
  end

  assign banderas = flags_q;

endmodule

// File: tb/tb_datapath_2.sv
// Directed self-checking bench for datapath_2: reset, ALU functions, flags, write-back timing.
module tb_datapath_2;

  logic        clk;
  logic        rst_n;
  logic [15:0] control;
  logic [3:0]  datain;
  logic [3:0]  banderas;
  logic [3:0]  dataout;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] PASSA = 4'h0, PASSB = 4'h1, ADD = 4'h2, SUB = 4'h3;
  localparam logic [3:0] AND_ = 4'h4, OR_ = 4'h5, XOR_ = 4'h6, NOTA = 4'h7;
  localparam logic [3:0] INC = 4'h8, DEC = 4'h9, SHL = 4'hA, SHR = 4'hB;
  localparam logic [3:0] ASR = 4'hC, ROL = 4'hD, ROR = 4'hE, ZERO = 4'hF;

  datapath_2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .datain   (datain),
    .banderas (banderas),
    .dataout  (dataout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] cw(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] d, input logic [3:0] op,
                                     input logic [2:0] os);
    return {a, b, d, op, os};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Show register k on dataout without writing anything.
  task automatic peek(input logic [2:0] k);
    control = cw(3'd0, 3'd0, 3'd0, ZERO, k);
    #1;
  endtask

  task automatic load(input logic [2:0] k, input logic [3:0] v);
    control = cw(3'd0, 3'd0, k, PASSA, 3'd0);
    datain  = v;
    step();
  endtask

  // Apply one op with dest, check the live result, then the flags after the edge.
  task automatic alu_case(input string name, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d, input logic [3:0] op,
                          input logic [3:0] exp_r, input logic [3:0] exp_f);
    control = cw(a, b, d, op, 3'd0);
    #1;
    checks++;
    if (dataout !== exp_r) begin
      errors++;
      $display("FAIL %s result: got %b expected %b", name, dataout, exp_r);
    end
    step();
    checks++;
    if (banderas !== exp_f) begin
      errors++;
      $display("FAIL %s flags: got %b expected %b", name, banderas, exp_f);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    control = 16'hBEEF;
    datain  = 4'hA;
    step();
    checks++;
    if (banderas !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 0000", banderas);
    end
    for (int k = 1; k < 8; k++) begin
      peek(3'(k));
      checks++;
      if (dataout !== 4'b0000) begin
        errors++;
        $display("FAIL reset r%0d: got %b expected 0000", k, dataout);
      end
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load();
    control = cw(3'd0, 3'd0, 3'd1, PASSA, 3'd0);
    datain  = 4'b0011;
    step();
    checks++;
    if (banderas !== 4'b0000) begin
      errors++;
      $display("FAIL load flags: got %b expected 0000", banderas);
    end
    peek(3'd1);
    checks++;
    if (dataout !== 4'b0011) begin
      errors++;
      $display("FAIL load r1: got %b expected 0011", dataout);
    end
  endtask

  task automatic test_copy();
    control = cw(3'd1, 3'd0, 3'd2, PASSA, 3'd0);
    datain  = 4'b1010;
    step();
    peek(3'd2);
    checks++;
    if (dataout !== 4'b0011) begin
      errors++;
      $display("FAIL copy r2: got %b expected 0011", dataout);
    end
    peek(3'd1);
    checks++;
    if (dataout !== 4'b0011) begin
      errors++;
      $display("FAIL copy r1 kept: got %b expected 0011", dataout);
    end
  endtask

  task automatic test_add();
    alu_case("add 3+3", 3'd1, 3'd2, 3'd3, ADD, 4'b0110, 4'b0000);
    peek(3'd3);
    checks++;
    if (dataout !== 4'b0110) begin
      errors++;
      $display("FAIL add r3: got %b expected 0110", dataout);
    end
    load(3'd1, 4'b0111);
    load(3'd2, 4'b0001);
    alu_case("add 7+1", 3'd1, 3'd2, 3'd4, ADD, 4'b1000, 4'b1001);
    peek(3'd4);
    checks++;
    if (dataout !== 4'b1000) begin
      errors++;
      $display("FAIL add r4: got %b expected 1000", dataout);
    end
    load(3'd1, 4'b1111);
    alu_case("add 15+1", 3'd1, 3'd2, 3'd4, ADD, 4'b0000, 4'b0110);
  endtask

  task automatic test_sub_shift();
    load(3'd1, 4'b0101);
    alu_case("sub a=b", 3'd1, 3'd1, 3'd5, SUB, 4'b0000, 4'b0110);
    load(3'd1, 4'b0011);
    load(3'd2, 4'b0101);
    alu_case("sub 3-5", 3'd1, 3'd2, 3'd5, SUB, 4'b1110, 4'b1000);
    load(3'd1, 4'b1001);
    alu_case("shl", 3'd1, 3'd0, 3'd6, SHL, 4'b0010, 4'b0010);
    alu_case("shr", 3'd1, 3'd0, 3'd0, SHR, 4'b0100, 4'b0010);
    alu_case("rol", 3'd1, 3'd0, 3'd0, ROL, 4'b0011, 4'b0010);
    load(3'd1, 4'b0001);
    alu_case("ror", 3'd1, 3'd0, 3'd6, ROR, 4'b1000, 4'b1010);
    load(3'd1, 4'b1000);
    alu_case("asr", 3'd1, 3'd0, 3'd6, ASR, 4'b1100, 4'b1000);
    alu_case("dec 8", 3'd1, 3'd0, 3'd0, DEC, 4'b0111, 4'b0011);
    load(3'd1, 4'b1111);
    alu_case("inc 15", 3'd1, 3'd0, 3'd0, INC, 4'b0000, 4'b0110);
    load(3'd1, 4'b0000);
    alu_case("dec 0", 3'd1, 3'd0, 3'd0, DEC, 4'b1111, 4'b1000);
  endtask

  task automatic test_logic();
    logic [3:0] ops  [6];
    logic [3:0] exps [6];
    ops  = '{AND_, OR_, XOR_, NOTA, PASSB, ZERO};
    exps = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b1010, 4'b0000};
    load(3'd1, 4'b1100);
    load(3'd2, 4'b1010);
    for (int i = 0; i < 6; i++) begin
      control = cw(3'd1, 3'd2, 3'd0, ops[i], 3'd0);
      #1;
      checks++;
      if (dataout !== exps[i]) begin
        errors++;
        $display("FAIL logic op %h: got %b expected %b", ops[i], dataout, exps[i]);
      end
    end
  endtask

  task automatic test_nowrite();
    for (int k = 1; k < 8; k++) load(3'(k), 4'(k));
    alu_case("nowrite add", 3'd7, 3'd7, 3'd0, ADD, 4'b1110, 4'b1001);
    for (int k = 1; k < 8; k++) begin
      peek(3'(k));
      checks++;
      if (dataout !== 4'(k)) begin
        errors++;
        $display("FAIL nowrite r%0d: got %b expected %b", k, dataout, 4'(k));
      end
    end
  endtask

  task automatic test_hazard();
    load(3'd3, 4'b0011);
    control = cw(3'd3, 3'd0, 3'd3, INC, 3'd3);
    #1;
    checks++;
    if (dataout !== 4'b0011) begin
      errors++;
      $display("FAIL hazard old r3: got %b expected 0011", dataout);
    end
    step();
    checks++;
    if (dataout !== 4'b0100) begin
      errors++;
      $display("FAIL hazard new r3: got %b expected 0100", dataout);
    end
  endtask

  task automatic test_async_reset();
    load(3'd1, 4'b1001);
    control = cw(3'd0, 3'd0, 3'd2, PASSA, 3'd0);
    datain  = 4'b0101;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (banderas !== 4'b0000) begin
      errors++;
      $display("FAIL async flags: got %b expected 0000", banderas);
    end
    peek(3'd1);
    checks++;
    if (dataout !== 4'b0000) begin
      errors++;
      $display("FAIL async r1: got %b expected 0000", dataout);
    end
    control = cw(3'd0, 3'd0, 3'd2, PASSA, 3'd0);
    step();
    rst_n = 1'b1;
    peek(3'd2);
    checks++;
    if (dataout !== 4'b0000) begin
      errors++;
      $display("FAIL async pending write: got %b expected 0000", dataout);
    end
    control = cw(3'd0, 3'd0, 3'd2, PASSA, 3'd0);
    step();
    peek(3'd2);
    checks++;
    if (dataout !== 4'b0101) begin
      errors++;
      $display("FAIL async recover r2: got %b expected 0101", dataout);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_copy();
    test_add();
    test_sub_shift();
    test_logic();
    test_nowrite();
    test_hazard();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
